// File: rtl/pipelined_add_sub.sv
// Pipelined N-bit adder/subtractor with ARM-style NZCV flags.
// The add is split into CHUNK-bit slices. Each pipeline stage adds one slice and
// registers its carry for the next stage. Every stage shifts on a single global
// advance enable, so a stalled output freezes the whole pipe and no op is dropped.
module pipelined_add_sub #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  input  logic [1:0]   i_op,
  input  logic         i_cin,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_sum,
  output logic [3:0]   o_flags
);

  localparam int STAGES = N / CHUNK;

  // Stage registers. Stage k holds the partial sum for bits below (k+1)*CHUNK,
  // the carry out of its slice, and the full operands for the later slices.
  logic         vld_q   [STAGES];
  logic [N-1:0] a_q     [STAGES];
  logic [N-1:0] b_q     [STAGES];
  logic [N-1:0] sum_q   [STAGES];
  logic         carry_q [STAGES];
  logic [3:0]   flags_q;

  // Stage inputs and the combinational slice results.
  logic         vld_in  [STAGES];
  logic [N-1:0] a_in    [STAGES];
  logic [N-1:0] b_in    [STAGES];
  logic [N-1:0] sum_in  [STAGES];
  logic         c_in    [STAGES];
  logic [CHUNK:0] part  [STAGES];
  logic [N-1:0] sum_d   [STAGES];
  logic         carry_d [STAGES];
  logic         ovf_d;
  logic         adv;
  logic         c0;
  logic [N-1:0] b_form;
  int           prev;

  // Pipe moves whenever the output slot is empty or being consumed.
  always_comb begin
    adv     = !vld_q[STAGES-1] || i_ready;
    o_ready = adv;
  end

  // Operand conditioning: subtraction becomes A + ~B + carry-in.
  always_comb begin
    b_form = i_op[1] ? ~i_y : i_y;
    case (i_op)
      2'b00:   c0 = 1'b0;
      2'b10:   c0 = 1'b1;
      default: c0 = i_cin;
    endcase
  end

  // Per-stage slice adders; stage 0 is fed straight from the input port.
  always_comb begin
    prev = 0;
    for (int k = 0; k < STAGES; k++) begin
      prev = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        vld_in[k] = i_valid;
        a_in[k]   = i_x;
        b_in[k]   = b_form;
        sum_in[k] = '0;
        c_in[k]   = c0;
      end else begin
        vld_in[k] = vld_q[prev];
        a_in[k]   = a_q[prev];
        b_in[k]   = b_q[prev];
        sum_in[k] = sum_q[prev];
        c_in[k]   = carry_q[prev];
      end
      part[k]  = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
               + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, c_in[k]};
      sum_d[k] = sum_in[k];
      sum_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      carry_d[k] = part[k][CHUNK];
    end
    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    ovf_d = part[STAGES-1][CHUNK]
          ^ (part[STAGES-1][CHUNK-1] ^ a_in[STAGES-1][N-1] ^ b_in[STAGES-1][N-1]);
  end

  // Shift all stages together on advance; hold everything while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]   <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      flags_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]   <= vld_in[k];
        a_q[k]     <= a_in[k];
        b_q[k]     <= b_in[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
      end
      flags_q <= {sum_d[STAGES-1][N-1], (sum_d[STAGES-1] == '0),
                  carry_d[STAGES-1], ovf_d};
    end
  end

  // The last stage register is the output slot.
  always_comb begin
    o_valid = vld_q[STAGES-1];
    o_sum   = sum_q[STAGES-1];
    o_flags = flags_q;
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Testbench for pipelined_add_sub: directed vectors, stall, mid-flight reset and
// a randomized regression against an arithmetic reference model.
module tb_pipelined_add_sub;

  localparam int N      = 32;
  localparam int CHUNK  = 8;
  localparam int STAGES = N / CHUNK;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_x;
  logic [N-1:0] i_y;
  logic [1:0]   i_op;
  logic         i_cin;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_sum;
  logic [3:0]   o_flags;

  int tests_run    = 0;
  int failed       = 0;
  int results_seen = 0;
  int ops_accepted = 0;

  logic [N+3:0] exp_q[$];

  pipelined_add_sub #(.N(N), .CHUNK(CHUNK)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_x     (i_x),
    .i_y     (i_y),
    .i_op    (i_op),
    .i_cin   (i_cin),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_flags (o_flags)
  );

  // Free-running clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Reference: wide arithmetic sum, flags from signs. Returns {N,Z,C,V,sum}.
  function automatic logic [N+3:0] refModel(input logic [N-1:0] x, input logic [N-1:0] y,
                                            input logic [1:0] op, input logic cin);
    logic [N-1:0] bop;
    logic         c;
    logic [N:0]   full;
    logic [N-1:0] s;
    logic         v;
    bop  = op[1] ? ~y : y;
    c    = (op == 2'b00) ? 1'b0 : (op == 2'b10) ? 1'b1 : cin;
    full = {1'b0, x} + {1'b0, bop} + {{N{1'b0}}, c};
    s    = full[N-1:0];
    v    = (x[N-1] == bop[N-1]) && (s[N-1] != x[N-1]);
    return {s[N-1], (s == '0), full[N], v, s};
  endfunction

  function automatic logic [N-1:0] pickOperand();
    logic [N-1:0] corners [4];
    corners[0] = '0;
    corners[1] = '1;
    corners[2] = {1'b1, {(N-1){1'b0}}};
    corners[3] = {1'b0, {(N-1){1'b1}}};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return N'($urandom);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        failed++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // One cycle: drive at the negedge, settle, score any transfers, step to the next negedge.
  task automatic applyStimulus(input logic v, input logic [N-1:0] x, input logic [N-1:0] y,
                               input logic [1:0] op, input logic cin, input logic rdy,
                               output logic acc, output logic rdy_seen);
    logic [N+3:0] head;
    i_valid = v;
    i_x     = x;
    i_y     = y;
    i_op    = op;
    i_cin   = cin;
    i_ready = rdy;
    #1;
    rdy_seen = o_ready;
    acc      = i_valid && o_ready;
    if (o_valid && i_ready) begin
      checkOutput("out_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        head = exp_q.pop_front();
        checkOutput("sum", 64'(o_sum), 64'(head[N-1:0]));
        checkOutput("flags", 64'(o_flags), 64'(head[N+3:N]));
        results_seen++;
      end
    end
    if (acc) begin
      exp_q.push_back(refModel(x, y, op, cin));
      ops_accepted++;
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic directedOp(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                            input logic [1:0] op, input logic cin,
                            input logic [N-1:0] exp_sum, input logic [3:0] exp_flags);
    logic acc;
    logic rs;
    int   lat;
    applyStimulus(1'b1, x, y, op, cin, 1'b1, acc, rs);
    checkOutput({tag, "_accept"}, 64'(acc), 64'd1);
    lat = 0;
    while (!o_valid && lat < 10) begin
      applyStimulus(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, acc, rs);
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(STAGES - 1));
    checkOutput({tag, "_sum"}, 64'(o_sum), 64'(exp_sum));
    checkOutput({tag, "_flags"}, 64'(o_flags), 64'(exp_flags));
    applyStimulus(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, acc, rs);
  endtask

  initial begin
    logic acc;
    logic rs;
    logic rdy;
    int   sent;
    int   base;
    int   cycles;

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_x     = '0;
    i_y     = '0;
    i_op    = 2'b00;
    i_cin   = 1'b0;
    i_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge i_clk);
    #1;
    checkOutput("reset_valid", 64'(o_valid), 64'd0);
    checkOutput("reset_sum", 64'(o_sum), 64'd0);
    checkOutput("reset_flags", 64'(o_flags), 64'd0);
    i_rst_n = 1'b1;
    #1;
    checkOutput("reset_ready", 64'(o_ready), 64'd1);
    @(negedge i_clk);

    // Directed arithmetic vectors, flags {N,Z,C,V}.
    directedOp("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h8000_0000, 4'b1001);
    directedOp("sub_eq",  32'h0000_0005, 32'h0000_0005, 2'b10, 1'b0, 32'h0000_0000, 4'b0110);
    directedOp("sub_neg", 32'h0000_0000, 32'h0000_0001, 2'b10, 1'b0, 32'hFFFF_FFFF, 4'b1000);
    directedOp("adc_rip", 32'hFFFF_FFFF, 32'h0000_0000, 2'b01, 1'b1, 32'h0000_0000, 4'b0110);
    directedOp("sbc_ovf", 32'h8000_0000, 32'h0000_0001, 2'b11, 1'b1, 32'h7FFF_FFFF, 4'b0011);
    directedOp("add_cin", 32'h0000_0010, 32'h0000_0020, 2'b00, 1'b1, 32'h0000_0030, 4'b0000);

    // Six back-to-back ops with downstream stalled for three cycles.
    sent = 0;
    base = results_seen;
    for (int cyc = 0; cyc < 40; cyc++) begin
      rdy = !(cyc >= 4 && cyc <= 6);
      applyStimulus(sent < 6, pickOperand(), pickOperand(), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), rdy, acc, rs);
      if (cyc >= 3 && cyc <= 7) checkOutput("stall_ready", 64'(rs), 64'(rdy));
      if (acc) sent++;
    end
    checkOutput("stall_count", 64'(results_seen - base), 64'd6);
    checkOutput("stall_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with ops in flight.
    applyStimulus(1'b1, 32'h0, 32'h1, 2'b10, 1'b0, 1'b0, acc, rs);
    applyStimulus(1'b1, 32'h5, 32'h7, 2'b00, 1'b0, 1'b0, acc, rs);
    applyStimulus(1'b1, 32'h9, 32'h2, 2'b10, 1'b0, 1'b0, acc, rs);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, acc, rs);
    #1;
    checkOutput("flight_valid", 64'(o_valid), 64'd1);
    #1;
    i_rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(o_valid), 64'd0);
    checkOutput("arst_flags", 64'(o_flags), 64'd0);
    checkOutput("arst_sum", 64'(o_sum), 64'd0);
    exp_q.delete();
    ops_accepted = results_seen;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      applyStimulus(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, acc, rs);
      checkOutput("post_rst_valid", 64'(o_valid), 64'd0);
    end

    // Randomized regression with random valid/ready.
    sent   = 0;
    cycles = 0;
    while (sent < 3000 && cycles < 20000) begin
      applyStimulus($urandom_range(0, 3) != 0, pickOperand(), pickOperand(),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0, acc, rs);
      if (acc) sent++;
      cycles++;
    end
    checkOutput("rand_progress", 64'(sent), 64'd3000);
    for (int cyc = 0; cyc < 20; cyc++)
      applyStimulus(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, acc, rs);
    checkOutput("rand_count", 64'(results_seen), 64'(ops_accepted));
    checkOutput("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
